// File: rtl/fp32_norm_round.sv
// Two-stage normalize-and-round back end for the binary32 add/sub datapath.
// Stage 1 normalizes the raw magnitude. Stage 2 rounds, packs and flags the result.
module fp32_norm_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [27:0] in_mant,
    input  logic        in_sticky,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic               s1_valid;
    logic               s1_sign;
    logic signed [10:0] s1_exp;
    logic [26:0]        s1_mant;
    logic               s1_sticky;
    logic [2:0]         s1_rm;

    logic               adv2;
    logic [4:0]         lz;
    logic [26:0]        n_norm;
    logic signed [10:0] exp_ext;
    logic signed [10:0] e_norm;

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;

    always_comb begin
        lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (in_mant[i]) lz = 5'(26 - i);
        end
        exp_ext = $signed({in_exp[9], in_exp});
        if (in_mant[27]) begin
            n_norm = {in_mant[27:2], in_mant[1] | in_mant[0]};
            e_norm = exp_ext + 11'sd1;
        end else begin
            n_norm = in_mant[26:0] << lz;
            e_norm = exp_ext - $signed({6'd0, lz});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_exp    <= e_norm;
                s1_mant   <= n_norm;
                s1_sticky <= in_sticky;
                s1_rm     <= in_rm;
            end
        end
    end

    // A normalized nonzero magnitude always has bit 26 set, so its absence marks a true zero.
    logic               s1_zero;
    logic               g_bit;
    logic               s_bit;
    logic               inc;
    logic [23:0]        frac_sum;
    logic signed [10:0] e_rnd;
    logic               nx;
    logic               to_inf;
    logic [31:0]        res_next;
    logic [4:0]         flags_next;

    always_comb begin
        s1_zero  = !s1_mant[26];
        g_bit    = s1_mant[2];
        s_bit    = s1_mant[1] | s1_mant[0] | s1_sticky;
        nx       = g_bit | s_bit;
        case (s1_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1_sign & nx;
            RM_RUP:  inc = !s1_sign & nx;
            RM_RMM:  inc = g_bit;
            default: inc = g_bit & (s_bit | s1_mant[3]);
        endcase
        frac_sum = {1'b0, s1_mant[25:3]} + {23'd0, inc};
        e_rnd    = s1_exp + $signed({10'd0, frac_sum[23]});
        case (s1_rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = s1_sign;
            RM_RUP:  to_inf = !s1_sign;
            default: to_inf = 1'b1;
        endcase

        res_next   = {s1_sign, 8'd0, 23'd0};
        flags_next = 5'b00000;
        if (s1_zero) begin
            res_next   = {s1_sign, 31'd0};
            flags_next = 5'b00000;
        end else if (s1_exp <= 11'sd0) begin
            res_next   = {s1_sign, 31'd0};
            flags_next = 5'b00011;
        end else if (e_rnd >= 11'sd255) begin
            res_next   = to_inf ? {s1_sign, 8'hFF, 23'd0} : {s1_sign, 8'hFE, 23'h7FFFFF};
            flags_next = 5'b00101;
        end else begin
            res_next   = {s1_sign, e_rnd[7:0], frac_sum[22:0]};
            flags_next = {4'b0000, nx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_next;
                out_flags  <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_fp32_norm_round.sv
// Directed-vector bench for fp32_norm_round: rounding modes, overflow/underflow,
// zero handling, backpressure and mid-flight reset.
module tb_fp32_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        in_sticky;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp32_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectBit(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic loadBeat(input logic s, input logic [9:0] e, input logic [27:0] m,
                            input logic st, input logic [2:0] rm);
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        in_sticky = st;
        in_rm     = rm;
    endtask

    // Presents one beat and returns #1 after the edge on which it was accepted.
    task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [27:0] m,
                                 input logic st, input logic [2:0] rm);
        int n = 0;
        loadBeat(s, e, m, st, rm);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        expectBit("accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] er, input logic [4:0] ef);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        assert ({out_valid, out_result, out_flags} === {1'b1, er, ef}) else begin
            bad++;
            $error("[TB] FAIL %s observed valid=%b result=%h flags=%b expected valid=1 result=%h flags=%b",
                   tag, out_valid, out_result, out_flags, er, ef);
        end
        tick();
    endtask

    logic [27:0] fc_mant [4];
    logic [9:0]  fc_exp  [4];
    logic [31:0] fc_res  [4];

    initial begin
        int in_idx;
        int out_idx;
        logic take_in;
        logic take_out;
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        loadBeat(1'b0, 10'd0, 28'd0, 1'b0, 3'd0);
        repeat (3) tick();
        expectBit("rst_out_valid", out_valid, 1'b0);
        total++;
        assert ({out_result, out_flags} === 37'd0) else begin
            bad++;
            $error("[TB] FAIL rst_data observed=%h/%b expected=0/0", out_result, out_flags);
        end
        expectBit("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Two-register latency: nothing visible right after acceptance, valid one edge later.
        applyStimulus(1'b0, 10'd127, 28'h4000000, 1'b0, 3'd0);
        expectBit("lat_early", out_valid, 1'b0);
        tick();
        expectBit("lat_ontime", out_valid, 1'b1);
        checkOutput("one", 32'h3F800000, 5'b00000);

        applyStimulus(1'b0, 10'd127, 28'h8000000, 1'b0, 3'd0);
        checkOutput("carry", 32'h40000000, 5'b00000);
        applyStimulus(1'b0, 10'd150, 28'h0000008, 1'b0, 3'd0);
        checkOutput("lz23", 32'h3F800000, 5'b00000);

        applyStimulus(1'b0, 10'd127, 28'h4000004, 1'b0, 3'd0);
        checkOutput("tie_even", 32'h3F800000, 5'b00001);
        applyStimulus(1'b0, 10'd127, 28'h400000C, 1'b0, 3'd0);
        checkOutput("tie_odd", 32'h3F800002, 5'b00001);
        applyStimulus(1'b0, 10'd127, 28'h4000004, 1'b1, 3'd0);
        checkOutput("tie_sticky", 32'h3F800001, 5'b00001);
        applyStimulus(1'b0, 10'd127, 28'h400000C, 1'b0, 3'd7);
        checkOutput("rm7_as_rne", 32'h3F800002, 5'b00001);
        applyStimulus(1'b0, 10'd127, 28'h4000004, 1'b0, 3'd4);
        checkOutput("rmm_tie", 32'h3F800001, 5'b00001);
        applyStimulus(1'b0, 10'd127, 28'h4000004, 1'b0, 3'd2);
        checkOutput("rdn_pos", 32'h3F800000, 5'b00001);
        applyStimulus(1'b1, 10'd127, 28'h4000001, 1'b0, 3'd2);
        checkOutput("rdn_neg", 32'hBF800001, 5'b00001);
        applyStimulus(1'b0, 10'd127, 28'h4000001, 1'b0, 3'd3);
        checkOutput("rup_pos", 32'h3F800001, 5'b00001);

        applyStimulus(1'b0, 10'd254, 28'h7FFFFFC, 1'b0, 3'd0);
        checkOutput("ovf_rne", 32'h7F800000, 5'b00101);
        // Truncation lands exactly on max finite with the exponent still 254, so only NX is raised.
        applyStimulus(1'b0, 10'd254, 28'h7FFFFFC, 1'b0, 3'd1);
        checkOutput("rtz_maxfin", 32'h7F7FFFFF, 5'b00001);
        applyStimulus(1'b1, 10'd254, 28'h7FFFFFC, 1'b0, 3'd2);
        checkOutput("ovf_rdn_neg", 32'hFF800000, 5'b00101);
        applyStimulus(1'b0, 10'd255, 28'h4000000, 1'b0, 3'd1);
        checkOutput("ovf_rtz", 32'h7F7FFFFF, 5'b00101);
        applyStimulus(1'b1, 10'd255, 28'h4000000, 1'b0, 3'd3);
        checkOutput("ovf_rup_neg", 32'hFF7FFFFF, 5'b00101);

        applyStimulus(1'b0, 10'd3, 28'h0000010, 1'b0, 3'd0);
        checkOutput("uf_flush", 32'h00000000, 5'b00011);
        applyStimulus(1'b1, 10'd0, 28'h4000000, 1'b0, 3'd0);
        checkOutput("uf_neg", 32'h80000000, 5'b00011);
        applyStimulus(1'b0, 10'd0, 28'h8000000, 1'b0, 3'd0);
        checkOutput("min_normal", 32'h00800000, 5'b00000);
        applyStimulus(1'b1, 10'd5, 28'h0000000, 1'b1, 3'd3);
        checkOutput("neg_zero", 32'h80000000, 5'b00000);

        // Backpressure: out_ready low for the first four cycles of a four-beat burst.
        fc_exp[0] = 10'd127; fc_mant[0] = 28'h4000000; fc_res[0] = 32'h3F800000;
        fc_exp[1] = 10'd128; fc_mant[1] = 28'h4000000; fc_res[1] = 32'h40000000;
        fc_exp[2] = 10'd129; fc_mant[2] = 28'h4000000; fc_res[2] = 32'h40800000;
        fc_exp[3] = 10'd127; fc_mant[3] = 28'h6000000; fc_res[3] = 32'h3FC00000;
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (in_idx < 4);
            if (in_idx < 4) loadBeat(1'b0, fc_exp[in_idx], fc_mant[in_idx], 1'b0, 3'd0);
            #1;
            take_in  = in_valid && in_ready;
            take_out = out_valid && out_ready;
            if (cyc == 2 || cyc == 3) begin
                total++;
                assert (in_idx == 2 && in_ready === 1'b0 && out_valid === 1'b1 &&
                        out_result === fc_res[0] && out_flags === 5'b00000) else begin
                    bad++;
                    $error("[TB] FAIL stall_hold observed accepted=%0d in_ready=%b result=%h expected accepted=2 in_ready=0 result=%h",
                           in_idx, in_ready, out_result, fc_res[0]);
                end
            end
            if (take_out) begin
                total++;
                assert (out_result === fc_res[out_idx] && out_flags === 5'b00000) else begin
                    bad++;
                    $error("[TB] FAIL burst_order observed=%h expected=%h index=%0d",
                           out_result, fc_res[out_idx], out_idx);
                end
                out_idx++;
            end
            @(posedge clk);
            #1;
            if (take_in) in_idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        assert (out_idx == 4) else begin
            bad++;
            $error("[TB] FAIL burst_count observed=%0d expected=4", out_idx);
        end

        // Reset with one beat in each stage: everything in flight must vanish.
        loadBeat(1'b0, 10'd130, 28'h4000000, 1'b0, 3'd0);
        in_valid = 1'b1;
        tick();
        loadBeat(1'b0, 10'd131, 28'h4000000, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        expectBit("rst_flush", out_valid, 1'b0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        expectBit("no_stale", seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
